// File: rtl/patbuf_arbiter.sv
// Arbiter sharing the low/high pattern buffer pair between the PAT core and a host port.
// PAT has priority; a starvation counter forces a one-cycle PAT stall so the host is always served.
module patbuf_arbiter #(
  parameter int unsigned d_width      = 8,
  parameter int unsigned bufp_width   = 3,
  parameter int unsigned fieldp_width = 5,
  parameter int unsigned starve_limit = 8,
  parameter int unsigned starve_width = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [bufp_width+fieldp_width-1:0]   pat_adr,
  input  logic [bufp_width+fieldp_width-1:0]   pat_wadr,
  input  logic                                 pat_rd,
  input  logic                                 pat_we_low,
  input  logic                                 pat_we_high,
  input  logic [d_width-1:0]                   pat_wdata,
  output logic [d_width-1:0]                   pat_rdata_low,
  output logic [d_width-1:0]                   pat_rdata_high,
  output logic                                 pat_stall,
  input  logic                                 host_req,
  input  logic                                 host_we,
  input  logic                                 host_sel,
  input  logic [bufp_width+fieldp_width-1:0]   host_adr,
  input  logic [d_width-1:0]                   host_wdata,
  output logic                                 host_gnt,
  output logic                                 host_rvalid,
  output logic [d_width-1:0]                   host_rdata,
  output logic [bufp_width+fieldp_width-1:0]   mem_adr,
  output logic [bufp_width+fieldp_width-1:0]   mem_wadr,
  output logic                                 mem_we_low,
  output logic                                 mem_we_high,
  output logic [d_width-1:0]                   mem_wdata,
  input  logic [d_width-1:0]                   mem_rdata_low,
  input  logic [d_width-1:0]                   mem_rdata_high
);

  localparam logic [starve_width-1:0] STARVE_LAST = starve_width'(starve_limit - 1);

  typedef enum logic {
    ST_PAT,
    ST_FORCE
  } state_t;

  state_t                  state;
  logic [starve_width-1:0] starve_cnt;
  logic                    pat_act;
  logic                    host_own;
  logic                    host_rd_gnt;

  // Ownership is decided from live inputs plus registered state; reset blocks any grant.
  always_comb begin
    pat_act     = pat_rd | pat_we_low | pat_we_high;
    host_own    = ~reset & host_req & ((state == ST_FORCE) | ~pat_act);
    host_rd_gnt = host_own & ~host_we;
    host_gnt    = host_own;
    pat_stall   = ~reset & (state == ST_FORCE) & host_req & pat_act;
  end

  always_comb begin
    mem_adr     = pat_adr;
    mem_wadr    = pat_wadr;
    mem_wdata   = pat_wdata;
    mem_we_low  = '0;
    mem_we_high = '0;
    if (host_own) begin
      mem_adr     = host_adr;
      mem_wadr    = host_adr;
      mem_wdata   = host_wdata;
      mem_we_low  = host_we & ~host_sel;
      mem_we_high = host_we & host_sel;
    end else if (!reset) begin
      mem_we_low  = pat_we_low;
      mem_we_high = pat_we_high;
    end
  end

  assign pat_rdata_low  = mem_rdata_low;
  assign pat_rdata_high = mem_rdata_high;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_PAT;
      starve_cnt  <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_rd_gnt;
      if (host_rd_gnt) begin
        host_rdata <= host_sel ? mem_rdata_high : mem_rdata_low;
      end
      case (state)
        ST_PAT: begin
          if (host_req && pat_act) begin
            starve_cnt <= starve_cnt + 1'b1;
            // Comparing the pre-increment count gives exactly starve_limit denied cycles.
            if (starve_cnt == STARVE_LAST) begin
              state <= ST_FORCE;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        ST_FORCE: begin
          starve_cnt <= '0;
          state      <= ST_PAT;
        end
        default: begin
          starve_cnt <= '0;
          state      <= ST_PAT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_patbuf_arbiter.sv
// Self-checking bench for patbuf_arbiter with a behavioural pair of pattern buffers.
// Host read data and accepted PAT writes go through scoreboard queues.
module tb_patbuf_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pat_adr, pat_wadr, pat_wdata;
  logic       pat_rd, pat_we_low, pat_we_high;
  logic [7:0] pat_rdata_low, pat_rdata_high;
  logic       pat_stall;
  logic       host_req, host_we, host_sel;
  logic [7:0] host_adr, host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic [7:0] mem_adr, mem_wadr, mem_wdata;
  logic       mem_we_low, mem_we_high;
  logic [7:0] mem_rdata_low, mem_rdata_high;

  logic [7:0] mem_low  [256];
  logic [7:0] mem_high [256];

  logic [7:0]  rd_q  [$];
  logic [15:0] pat_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  patbuf_arbiter #(
    .d_width(8), .bufp_width(3), .fieldp_width(5), .starve_limit(8), .starve_width(4)
  ) dut (
    .clk(clk), .reset(reset),
    .pat_adr(pat_adr), .pat_wadr(pat_wadr), .pat_rd(pat_rd),
    .pat_we_low(pat_we_low), .pat_we_high(pat_we_high), .pat_wdata(pat_wdata),
    .pat_rdata_low(pat_rdata_low), .pat_rdata_high(pat_rdata_high), .pat_stall(pat_stall),
    .host_req(host_req), .host_we(host_we), .host_sel(host_sel),
    .host_adr(host_adr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_adr(mem_adr), .mem_wadr(mem_wadr), .mem_we_low(mem_we_low),
    .mem_we_high(mem_we_high), .mem_wdata(mem_wdata),
    .mem_rdata_low(mem_rdata_low), .mem_rdata_high(mem_rdata_high)
  );

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_low[i]  = 8'h00;
      mem_high[i] = 8'h00;
    end
  end

  always @(posedge clk) begin
    if (mem_we_low)  mem_low[mem_wadr]  <= mem_wdata;
    if (mem_we_high) mem_high[mem_wadr] <= mem_wdata;
  end
  assign mem_rdata_low  = mem_low[mem_adr];
  assign mem_rdata_high = mem_high[mem_adr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    pat_adr = 8'h00; pat_wadr = 8'h00; pat_wdata = 8'h00;
    pat_rd = 1'b0; pat_we_low = 1'b0; pat_we_high = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_sel = 1'b0;
    host_adr = 8'h00; host_wdata = 8'h00;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    #2;
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", host_gnt); end
    checks++; if (pat_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", pat_stall); end
    checks++; if ({mem_we_low, mem_we_high} !== 2'b00) begin errors++; $display("FAIL reset_we got %b want 00", {mem_we_low, mem_we_high}); end
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", host_rvalid); end
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", host_rdata); end
    checks++; if ({mem_adr, mem_wadr, mem_wdata} !== 24'h0) begin errors++; $display("FAIL reset_mem_bus got %h want 000000", {mem_adr, mem_wadr, mem_wdata}); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_host_write;
    tick();
    host_req = 1'b1; host_we = 1'b1; host_sel = 1'b0; host_adr = 8'h05; host_wdata = 8'hA5;
    #2;
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL hw_gnt got %b want 1", host_gnt); end
    checks++; if ({mem_we_low, mem_we_high} !== 2'b10) begin errors++; $display("FAIL hw_we got %b want 10", {mem_we_low, mem_we_high}); end
    checks++; if ({mem_wadr, mem_wdata} !== 16'h05A5) begin errors++; $display("FAIL hw_bus got %h want 05a5", {mem_wadr, mem_wdata}); end
    tick();
    idle_inputs();
    #2;
    checks++; if (mem_low[5] !== 8'hA5) begin errors++; $display("FAIL hw_mem got %h want a5", mem_low[5]); end
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL hw_rvalid got %b want 0", host_rvalid); end
  endtask

  task automatic test_host_read;
    logic [7:0] exp;
    tick();
    host_req = 1'b1; host_we = 1'b0; host_sel = 1'b0; host_adr = 8'h05;
    #2;
    checks++; if ({host_gnt, mem_we_low, mem_we_high} !== 3'b100) begin errors++; $display("FAIL hr_gnt got %b want 100", {host_gnt, mem_we_low, mem_we_high}); end
    rd_q.push_back(8'hA5);
    tick();
    idle_inputs();
    #2;
    checks++; if (host_rvalid !== 1'b1) begin errors++; $display("FAIL hr_rvalid got %b want 1", host_rvalid); end
    exp = rd_q.pop_front();
    checks++; if (host_rdata !== exp) begin errors++; $display("FAIL hr_rdata got %h want %h", host_rdata, exp); end
    tick();
    #2;
    checks++; if ({host_rvalid, host_rdata} !== {1'b0, exp}) begin errors++; $display("FAIL hr_hold got %b/%h want 0/%h", host_rvalid, host_rdata, exp); end
  endtask

  task automatic test_starvation;
    logic [7:0] exp;
    tick();
    idle_inputs();
    tick();
    pat_rd = 1'b1; pat_adr = 8'h00;
    host_req = 1'b1; host_we = 1'b0; host_sel = 1'b0; host_adr = 8'h05;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (c < 8) begin
        checks++; if ({host_gnt, pat_stall} !== 2'b00) begin errors++; $display("FAIL starve_deny c=%0d got %b want 00", c, {host_gnt, pat_stall}); end
      end else if (c == 8) begin
        checks++; if ({host_gnt, pat_stall} !== 2'b11) begin errors++; $display("FAIL starve_force got %b want 11", {host_gnt, pat_stall}); end
        rd_q.push_back(8'hA5);
      end else begin
        checks++; if ({host_gnt, pat_stall} !== 2'b00) begin errors++; $display("FAIL starve_after got %b want 00", {host_gnt, pat_stall}); end
        if (host_rvalid === 1'b1 && rd_q.size() > 0) begin
          exp = rd_q.pop_front();
          checks++; if (host_rdata !== exp) begin errors++; $display("FAIL starve_rdata got %h want %h", host_rdata, exp); end
        end else begin
          checks++; errors++; $display("FAIL starve_rvalid got %b want 1", host_rvalid);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_force_write;
    tick();
    idle_inputs();
    tick();
    pat_rd = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_sel = 1'b1; host_adr = 8'h10; host_wdata = 8'hC3;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) begin
        pat_rd = 1'b0; pat_we_high = 1'b1; pat_wadr = 8'h20; pat_wdata = 8'h33;
      end
      #2;
      if (c < 8) begin
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL fw_deny c=%0d got %b want 0", c, host_gnt); end
      end else begin
        checks++; if ({host_gnt, pat_stall, mem_we_low, mem_we_high} !== 4'b1101) begin errors++; $display("FAIL fw_force got %b want 1101", {host_gnt, pat_stall, mem_we_low, mem_we_high}); end
        checks++; if ({mem_wadr, mem_wdata} !== 16'h10C3) begin errors++; $display("FAIL fw_bus got %h want 10c3", {mem_wadr, mem_wdata}); end
      end
      tick();
    end
    host_req = 1'b0; host_we = 1'b0;
    #2;
    checks++; if ({mem_high[8'h10], mem_high[8'h20]} !== 16'hC300) begin errors++; $display("FAIL fw_mem1 got %h want c300", {mem_high[8'h10], mem_high[8'h20]}); end
    checks++; if ({pat_stall, mem_we_high, mem_wadr} !== {2'b01, 8'h20}) begin errors++; $display("FAIL fw_retry got %b want 0100100000", {pat_stall, mem_we_high, mem_wadr}); end
    tick();
    idle_inputs();
    #2;
    checks++; if ({mem_high[8'h10], mem_high[8'h20]} !== 16'hC333) begin errors++; $display("FAIL fw_mem2 got %h want c333", {mem_high[8'h10], mem_high[8'h20]}); end
  endtask

  task automatic test_reset_force;
    int denied;
    tick();
    idle_inputs();
    tick();
    pat_rd = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_sel = 1'b0; host_adr = 8'h30; host_wdata = 8'h77;
    for (int c = 0; c < 8; c++) tick();
    reset = 1'b1;
    pat_we_low = 1'b1; pat_wadr = 8'h31; pat_wdata = 8'h11;
    #2;
    checks++; if ({host_gnt, pat_stall, mem_we_low, mem_we_high} !== 4'b0000) begin errors++; $display("FAIL rf_reset got %b want 0000", {host_gnt, pat_stall, mem_we_low, mem_we_high}); end
    tick();
    reset = 1'b0;
    pat_we_low = 1'b0;
    denied = 0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (host_gnt === 1'b1) break;
      denied++;
      tick();
    end
    checks++; if (denied !== 8) begin errors++; $display("FAIL rf_denied got %0d want 8", denied); end
    tick();
    idle_inputs();
    #2;
    checks++; if ({mem_low[8'h30], mem_low[8'h31]} !== 16'h7700) begin errors++; $display("FAIL rf_mem got %h want 7700", {mem_low[8'h30], mem_low[8'h31]}); end
  endtask

  task automatic test_random;
    logic       pat_pend = 1'b0;
    int         pat_idx = 0;
    int         wait_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [15:0] ent;
    tick();
    idle_inputs();
    host_req = 1'b1; host_we = 1'b1;
    host_sel = 1'($urandom_range(1)); host_adr = 8'($urandom_range(127)); host_wdata = 8'($urandom);
    for (int c = 0; c < 300; c++) begin
      if (!pat_pend && pat_idx < 127 && $urandom_range(1) == 1) begin
        pat_pend = 1'b1;
        pat_we_low = 1'b1; pat_wadr = 8'(8'h80 + pat_idx); pat_wdata = 8'(pat_idx) ^ 8'h5A;
      end
      #2;
      if (pat_pend && pat_stall === 1'b0) begin
        pat_q.push_back({pat_wadr, pat_wdata});
        pat_idx++;
        pat_pend = 1'b0;
      end
      if (pat_stall === 1'b1) begin
        checks++; if (prev_stall !== 1'b0) begin errors++; $display("FAIL rnd_double_stall c=%0d got 1 want 0", c); end
      end
      prev_stall = pat_stall;
      if (host_gnt === 1'b1) begin
        checks++; if (wait_cnt > 8) begin errors++; $display("FAIL rnd_wait c=%0d got %0d want <=8", c, wait_cnt); end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
      tick();
      if (!pat_pend) pat_we_low = 1'b0;
      if (wait_cnt == 0) begin
        host_sel = 1'($urandom_range(1)); host_adr = 8'($urandom_range(127)); host_wdata = 8'($urandom);
      end
    end
    checks++; if (wait_cnt > 8) begin errors++; $display("FAIL rnd_wait_end got %0d want <=8", wait_cnt); end
    idle_inputs();
    tick();
    checks++; if (pat_q.size() < 20) begin errors++; $display("FAIL rnd_pat_count got %0d want >=20", pat_q.size()); end
    while (pat_q.size() > 0) begin
      ent = pat_q.pop_front();
      checks++; if (mem_low[ent[15:8]] !== ent[7:0]) begin errors++; $display("FAIL rnd_pat_lost adr=%h got %h want %h", ent[15:8], mem_low[ent[15:8]], ent[7:0]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_host_write();
    test_host_read();
    test_starvation();
    test_force_write();
    test_reset_force();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
